nco_sweep_ctrl: RTL and testbench

//  Sequencer that drives the FREQ_WORD input of the NCO phase accumulator.

---
 rtl/nco_sweep_ctrl.sv | 164 ++++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_sweep_ctrl.sv
// Frequency-word sweep sequencer for the NCO phase accumulator.
// Optional build macro: NCO_SWEEP_TRIANGLE_EN (continuous up/down triangle sweep).
module nco_sweep_ctrl #(
    parameter int ACCUM_WIDTH = 32,
    parameter int DWELL_WIDTH = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   cfg_valid_i,
    output logic                   cfg_ready_o,
    input  logic [ACCUM_WIDTH-1:0] cfg_start_i,
    input  logic [ACCUM_WIDTH-1:0] cfg_stop_i,
    input  logic [ACCUM_WIDTH-1:0] cfg_step_i,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell_i,
    input  logic                   abort_i,
    output logic [ACCUM_WIDTH-1:0] freq_word_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [CNT_WIDTH-1:0]   sweep_count_o
);

    // state | meaning
    // IDLE  | waiting for a descriptor, cfg_ready high
    // DWELL | holding an intermediate word, stepping toward stop on expiry
    // FINAL | holding the stop word for one last dwell period
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DWELL = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;

    localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = {{(DWELL_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]   COUNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]             state_q, state_d;
    logic [ACCUM_WIDTH-1:0] stop_q, stop_d;
    logic [ACCUM_WIDTH-1:0] step_q, step_d;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
    logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
    logic [ACCUM_WIDTH-1:0] freq_q, freq_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   dir_up_q, dir_up_d;
    logic                   done_q, done_d;
`ifdef NCO_SWEEP_TRIANGLE_EN
    logic [ACCUM_WIDTH-1:0] start_q, start_d;
`endif

    logic [ACCUM_WIDTH:0]   step_sum;
    logic [ACCUM_WIDTH:0]   step_dif;
    logic                   up_hit;
    logic                   dn_hit;
    logic                   clamp;

    // The extra MSB catches accumulator carry/borrow so a step never wraps past stop.
    assign step_sum = {1'b0, freq_q} + {1'b0, step_q};
    assign step_dif = {1'b0, freq_q} - {1'b0, step_q};
    assign up_hit   = step_sum[ACCUM_WIDTH] || (step_sum[ACCUM_WIDTH-1:0] >= stop_q);
    assign dn_hit   = step_dif[ACCUM_WIDTH] || (step_dif[ACCUM_WIDTH-1:0] <= stop_q);
    assign clamp    = (step_q == '0) || (dir_up_q ? up_hit : dn_hit);

    always_comb begin
        state_d  = state_q;
        stop_d   = stop_q;
        step_d   = step_q;
        dwell_d  = dwell_q;
        cnt_d    = cnt_q;
        freq_d   = freq_q;
        count_d  = count_q;
        dir_up_d = dir_up_q;
        done_d   = 1'b0;
`ifdef NCO_SWEEP_TRIANGLE_EN
        start_d  = start_q;
`endif
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cfg_valid_i) begin
                        stop_d   = cfg_stop_i;
                        step_d   = cfg_step_i;
                        dwell_d  = cfg_dwell_i;
                        dir_up_d = (cfg_stop_i >= cfg_start_i);
                        freq_d   = cfg_start_i;
                        cnt_d    = cfg_dwell_i;
`ifdef NCO_SWEEP_TRIANGLE_EN
                        start_d  = cfg_start_i;
`endif
                        state_d  = (cfg_start_i == cfg_stop_i) ? S_FINAL : S_DWELL;
                    end
                end
                S_DWELL: begin
                    if (cnt_q == '0) begin
                        cnt_d = dwell_q;
                        if (clamp) begin
                            freq_d  = stop_q;
                            state_d = S_FINAL;
                        end else begin
                            freq_d = dir_up_q ? step_sum[ACCUM_WIDTH-1:0]
                                              : step_dif[ACCUM_WIDTH-1:0];
                        end
                    end else begin
                        cnt_d = cnt_q - DWELL_ONE;
                    end
                end
                S_FINAL: begin
                    if (cnt_q == '0) begin
                        count_d = count_q + COUNT_ONE;
`ifdef NCO_SWEEP_TRIANGLE_EN
                        // Reverse the leg; freq stays at the old stop, which is the new start.
                        start_d  = stop_q;
                        stop_d   = start_q;
                        dir_up_d = ~dir_up_q;
                        cnt_d    = dwell_q;
                        state_d  = S_DWELL;
`else
                        done_d   = 1'b1;
                        state_d  = S_IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q - DWELL_ONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            stop_q   <= '0;
            step_q   <= '0;
            dwell_q  <= '0;
            cnt_q    <= '0;
            freq_q   <= '0;
            count_q  <= '0;
            dir_up_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef NCO_SWEEP_TRIANGLE_EN
            start_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            stop_q   <= stop_d;
            step_q   <= step_d;
            dwell_q  <= dwell_d;
            cnt_q    <= cnt_d;
            freq_q   <= freq_d;
            count_q  <= count_d;
            dir_up_q <= dir_up_d;
            done_q   <= done_d;
`ifdef NCO_SWEEP_TRIANGLE_EN
            start_q  <= start_d;
`endif
        end
    end

    assign cfg_ready_o   = (state_q == S_IDLE);
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign freq_word_o   = freq_q;
    assign sweep_count_o = count_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: directed table, hand sequences and random sweeps
// against a word-list reference model.
module tb_nco_sweep_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        cfg_valid_i;
    logic        cfg_ready_o;
    logic [31:0] cfg_start_i;
    logic [31:0] cfg_stop_i;
    logic [31:0] cfg_step_i;
    logic [15:0] cfg_dwell_i;
    logic        abort_i;
    logic [31:0] freq_word_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] sweep_count_o;

    nco_sweep_ctrl #(.ACCUM_WIDTH(32), .DWELL_WIDTH(16), .CNT_WIDTH(16)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_start_i  (cfg_start_i),
        .cfg_stop_i   (cfg_stop_i),
        .cfg_step_i   (cfg_step_i),
        .cfg_dwell_i  (cfg_dwell_i),
        .abort_i      (abort_i),
        .freq_word_o  (freq_word_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .sweep_count_o(sweep_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] start;
        logic [31:0] stop;
        logic [31:0] step;
        logic [15:0] dwell;
        int          cycles;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_count = '0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: list the words of the sweep with wide arithmetic, each repeated dwell+1 times.
    task automatic model_fill(input logic [31:0] s, input logic [31:0] e,
                              input logic [31:0] st, input logic [15:0] dw);
        longint w, nxt, stopv;
        bit     up;
        exp_q.delete();
        w     = longint'(s);
        stopv = longint'(e);
        up    = (e >= s);
        while (exp_q.size() < 20000) begin
            for (int r = 0; r <= int'(dw); r++) exp_q.push_back(w[31:0]);
            if (w == stopv) break;
            nxt = up ? w + longint'(st) : w - longint'(st);
            if (st == 0 || (up ? nxt >= stopv : nxt <= stopv)) w = stopv;
            else w = nxt;
        end
    endtask

    task automatic run_desc(input logic [31:0] s, input logic [31:0] e,
                            input logic [31:0] st, input logic [15:0] dw, input int exp_cyc);
        int cyc;
        model_fill(s, e, st, dw);
        cfg_start_i = s;
        cfg_stop_i  = e;
        cfg_step_i  = st;
        cfg_dwell_i = dw;
        cfg_valid_i = 1'b1;
        chk("ready_idle", cfg_ready_o, 1);
        @(negedge clk_i);
        cfg_valid_i = 1'b0;
        cyc = 0;
        while (busy_o === 1'b1 && cyc < 4000) begin
            if (cyc < exp_q.size()) chk("freq", freq_word_o, exp_q[cyc]);
            else chk("overrun", cyc, exp_q.size());
            chk("ready_busy", cfg_ready_o, 0);
            chk("done_early", done_o, 0);
            // A foreign descriptor offered mid-sweep must be ignored.
            if (exp_q.size() > 3) begin
                cfg_valid_i = (cyc == 1);
                cfg_start_i = (cyc == 1) ? ~s : s;
            end
            cyc++;
            @(negedge clk_i);
        end
        cfg_valid_i = 1'b0;
        chk("busy_cycles", cyc, exp_q.size());
        if (exp_cyc > 0) chk("table_cycles", cyc, exp_cyc);
        exp_count++;
        chk("done", done_o, 1);
        chk("sweep_count", sweep_count_o, exp_count);
        chk("freq_final", freq_word_o, e);
        @(negedge clk_i);
        chk("done_pulse", done_o, 0);
    endtask

    vec_t tbl[7];

    initial begin
        logic [31:0] rs, re, rst;
        logic [15:0] rdw;
        tbl[0] = '{32'd100,        32'd130,        32'd10,   16'd1, 8};
        tbl[1] = '{32'd1000,       32'd975,        32'd10,   16'd0, 4};
        tbl[2] = '{32'hFFFF_FFF0,  32'hFFFF_FFFF,  32'h20,   16'd0, 2};
        tbl[3] = '{32'd500,        32'd500,        32'd7,    16'd3, 4};
        tbl[4] = '{32'd200,        32'd300,        32'd0,    16'd2, 6};
        tbl[5] = '{32'h10,         32'h0,          32'h20,   16'd0, 2};
        tbl[6] = '{32'd50,         32'd10,         32'd0,    16'd1, 4};

        rst_n_i     = 1'b0;
        cfg_valid_i = 1'b0;
        cfg_start_i = '0;
        cfg_stop_i  = '0;
        cfg_step_i  = '0;
        cfg_dwell_i = '0;
        abort_i     = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_freq", freq_word_o, 0);
        chk("rst_ready", cfg_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_count", sweep_count_o, 0);
        rst_n_i = 1'b1;
        @(negedge clk_i);

`ifdef NCO_SWEEP_TRIANGLE_EN
        begin
            logic [31:0] tri_exp[8];
            tri_exp = '{32'd0, 32'd10, 32'd20, 32'd20, 32'd10, 32'd0, 32'd0, 32'd10};
            cfg_start_i = 32'd0;
            cfg_stop_i  = 32'd20;
            cfg_step_i  = 32'd10;
            cfg_dwell_i = 16'd0;
            cfg_valid_i = 1'b1;
            @(negedge clk_i);
            cfg_valid_i = 1'b0;
            for (int i = 0; i < 8; i++) begin
                chk("tri_freq", freq_word_o, tri_exp[i]);
                chk("tri_done", done_o, 0);
                chk("tri_busy", busy_o, 1);
                @(negedge clk_i);
            end
            chk("tri_count", sweep_count_o, 2);
            abort_i = 1'b1;
            @(negedge clk_i);
            abort_i = 1'b0;
            chk("tri_abort_busy", busy_o, 0);
        end
`else
        for (int i = 0; i < 7; i++)
            run_desc(tbl[i].start, tbl[i].stop, tbl[i].step, tbl[i].dwell, tbl[i].cycles);

        // Abort on the third cycle of the first table sweep.
        cfg_start_i = 32'd100;
        cfg_stop_i  = 32'd130;
        cfg_step_i  = 32'd10;
        cfg_dwell_i = 16'd1;
        cfg_valid_i = 1'b1;
        @(negedge clk_i);
        cfg_valid_i = 1'b0;
        chk("ab_c1", freq_word_o, 100);
        @(negedge clk_i);
        chk("ab_c2", freq_word_o, 100);
        @(negedge clk_i);
        chk("ab_c3", freq_word_o, 110);
        abort_i = 1'b1;
        @(negedge clk_i);
        chk("ab_busy", busy_o, 0);
        chk("ab_freq_hold", freq_word_o, 110);
        chk("ab_done", done_o, 0);
        chk("ab_count", sweep_count_o, exp_count);
        // Abort beats a simultaneous descriptor in IDLE.
        cfg_valid_i = 1'b1;
        @(negedge clk_i);
        chk("ab_wins_busy", busy_o, 0);
        chk("ab_wins_freq", freq_word_o, 110);
        cfg_valid_i = 1'b0;
        abort_i     = 1'b0;
        run_desc(32'd1000, 32'd975, 32'd10, 16'd0, 4);

        // Reset mid-sweep returns every output to its reset value immediately.
        cfg_start_i = 32'd40;
        cfg_stop_i  = 32'd90;
        cfg_step_i  = 32'd5;
        cfg_dwell_i = 16'd0;
        cfg_valid_i = 1'b1;
        @(negedge clk_i);
        cfg_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("pre_rst_freq", freq_word_o, 55);
        rst_n_i = 1'b0;
        #1;
        chk("mid_rst_freq", freq_word_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_count", sweep_count_o, 0);
        chk("mid_rst_ready", cfg_ready_o, 1);
        exp_count = '0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        for (int n = 0; n < 30; n++) begin
            rst  = $urandom_range(0, 60);
            rdw  = 16'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: begin
                    re = 32'hFFFF_FFFF;
                    rs = re - 32'($urandom_range(0, 100));
                end
                1: begin
                    re = 32'd0;
                    rs = 32'($urandom_range(0, 100));
                end
                2: begin
                    rs = $urandom_range(0, 32'hFFFF_0000);
                    re = rs + 32'($urandom_range(0, 200));
                end
                default: begin
                    rs = $urandom_range(32'h0000_1000, 32'hFFFF_FFFF);
                    re = rs - 32'($urandom_range(0, 200));
                end
            endcase
            run_desc(rs, re, rst, rdw, 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
